// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 UART transmitter with a valid/ready byte FIFO in front of
//               a START/DATA/STOP serializer. Bits go out LSB first, each held
//               for CLK_DIV clocks; queued frames are sent back to back.
//               Optional odd parity bit when UART_TX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          txd_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          empty_o
);

    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_BAUD_W = $clog2(CLK_DIV);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;
`endif

    // FIFO
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                w_push;
    logic                w_pop;
    logic                w_not_empty;
    logic [7:0]          w_head;

    // Serializer
    state_t              r_state;
    state_t              w_state_next;
    logic [c_BAUD_W-1:0] r_baud;
    logic [c_BAUD_W-1:0] w_baud_next;
    logic [2:0]          r_bit_idx;
    logic [2:0]          w_bit_next;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_next;
    logic                w_tick;
    logic                r_txd;
    logic                w_txd_next;
    logic                r_busy;
`ifdef UART_TX_PARITY_EN
    logic                r_parity;
`endif

    assign ready_o      = (r_count != c_CNT_W'(FIFO_DEPTH));
    assign w_push       = valid_i && ready_o;
    assign w_not_empty  = (r_count != '0);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_tick       = (r_baud == c_BAUD_W'(CLK_DIV - 1));

    assign txd_o        = r_txd;
    assign busy_o       = r_busy;
    assign fifo_count_o = r_count;
    assign empty_o      = (r_count == '0) && !r_busy;

    // FIFO storage: data_i is captured only on an accepted transfer
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // FIFO pointers (power-of-two depth, so they wrap naturally) and occupancy
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Serializer state register; line and busy are registered from the
    // current state, so they trail the state machine by one clock
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_next;
            r_shift   <= w_shift_next;
            r_txd     <= w_txd_next;
            r_busy    <= (r_state != S_IDLE);
        end
    end

`ifdef UART_TX_PARITY_EN
    // Odd parity of the byte being loaded: inverted XOR of its data bits
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ~(^w_head);
        end
    end
`endif

    // Next-state, FIFO pop and line level
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        w_txd_next   = 1'b1;

        if (r_state != S_IDLE) begin
            w_baud_next = w_tick ? '0 : (r_baud + c_BAUD_W'(1));
        end

        case (r_state)
            S_IDLE: begin
                w_txd_next = 1'b1;
                if (w_not_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_baud_next  = '0;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_txd_next = 1'b0;
                if (w_tick) begin
                    w_bit_next   = 3'd0;
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_txd_next = r_shift[0];
                if (w_tick) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    w_bit_next   = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_txd_next = r_parity;
                if (w_tick) begin
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                w_txd_next = 1'b1;
                if (w_tick) begin
                    // Chain straight into the next START when more data waits
                    if (w_not_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
